// File: rtl/uart_mem_loader_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_mem_loader_if
// Brief    : Bundle of the UART boot-loader signals: serial input, external
//            data-memory write port and CPU release/status lines.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface uart_mem_loader_if;
  logic        rx;
  logic        ext_memwrite;
  logic [31:0] ext_writedata;
  logic [31:0] ext_dataadr;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  // Loader side: consumes the serial line, drives memory port and status
  modport master (
    input  rx,
    output ext_memwrite, ext_writedata, ext_dataadr,
    output cpu_reset, busy, done, err
  );

  // Environment side: drives the serial line, observes everything else
  modport slave (
    output rx,
    input  ext_memwrite, ext_writedata, ext_dataadr,
    input  cpu_reset, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_mem_loader
// Brief    : UART (8N1) boot loader. Receives a length-prefixed program image,
//            assembles little-endian 32-bit words, writes them to data memory
//            and then releases the CPU from reset.
// Options  : define UART_LOADER_CHECKSUM_EN to require a trailing XOR byte
//            over the whole frame before the CPU is released.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_mem_loader #(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic                clk,
  input  logic                reset,
  uart_mem_loader_if.master   ldIf
);

  localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]        c_MAX_WORDS = 16'(MAX_WORDS);

  //--------------------------------------------------------------------------
  // UART receiver
  //--------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxState_t;

  rxState_t             r_rxState;
  rxState_t             w_rxNext;
  logic                 r_rxMeta;
  logic                 r_rxSync;
  logic                 r_rxPrev;
  logic [c_CNT_W-1:0]   r_rxCnt;
  logic [2:0]           r_bitIdx;
  logic [7:0]           r_shift;
  logic                 r_byteValid;
  logic [7:0]           r_byteData;
  logic                 r_frameErr;
  logic                 w_cntHit;
  logic                 w_startOk;
  logic                 w_byteDone;
  logic                 w_frameErr;

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxMeta <= ldIf.rx;
      r_rxSync <= r_rxMeta;
      r_rxPrev <= r_rxSync;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rxState <= RX_IDLE;
    else       r_rxState <= w_rxNext;
  end

  // Receiver next state and sample strobes; START samples at mid-bit
  always_comb begin
    w_rxNext   = r_rxState;
    w_cntHit   = 1'b0;
    w_startOk  = 1'b0;
    w_byteDone = 1'b0;
    w_frameErr = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        if (r_rxPrev && !r_rxSync) w_rxNext = RX_START;
      end
      RX_START: begin
        w_cntHit = (r_rxCnt == c_HALF_LAST);
        if (w_cntHit) begin
          if (!r_rxSync) begin
            w_rxNext  = RX_DATA;
            w_startOk = 1'b1;
          end else begin
            w_rxNext = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        w_cntHit = (r_rxCnt == c_BIT_LAST);
        if (w_cntHit && (r_bitIdx == 3'd7)) w_rxNext = RX_STOP;
      end
      RX_STOP: begin
        w_cntHit = (r_rxCnt == c_BIT_LAST);
        if (w_cntHit) begin
          w_rxNext = RX_IDLE;
          if (r_rxSync) w_byteDone = 1'b1;
          else          w_frameErr = 1'b1;
        end
      end
      default: w_rxNext = RX_IDLE;
    endcase
  end

  // Bit timer, data shifter and one-cycle byte/framing-error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxCnt     <= '0;
      r_bitIdx    <= 3'd0;
      r_shift     <= 8'd0;
      r_byteValid <= 1'b0;
      r_byteData  <= 8'd0;
      r_frameErr  <= 1'b0;
    end else begin
      r_rxCnt <= ((r_rxState == RX_IDLE) || w_cntHit) ? '0 : r_rxCnt + 1'b1;
      if (w_startOk) begin
        r_bitIdx <= 3'd0;
      end else if ((r_rxState == RX_DATA) && w_cntHit) begin
        r_bitIdx <= r_bitIdx + 3'd1;
        r_shift  <= {r_rxSync, r_shift[7:1]};
      end
      r_byteValid <= w_byteDone;
      r_frameErr  <= w_frameErr;
      if (w_byteDone) r_byteData <= r_shift;
    end
  end

  //--------------------------------------------------------------------------
  // Image loader
  //--------------------------------------------------------------------------
  typedef enum logic [2:0] {
    LD_LEN_LO = 3'd0,
    LD_LEN_HI = 3'd1,
    LD_DATA   = 3'd2,
    LD_WRITE  = 3'd3,
`ifdef UART_LOADER_CHECKSUM_EN
    LD_CHK    = 3'd4,
`endif
    LD_DONE   = 3'd5,
    LD_ERROR  = 3'd6
  } ldState_t;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam ldState_t c_LD_FINISH = LD_CHK;
`else
  localparam ldState_t c_LD_FINISH = LD_DONE;
`endif

  ldState_t     r_ldState;
  ldState_t     w_ldNext;
  logic [15:0]  r_wordCount;
  logic [15:0]  r_wordIdx;
  logic [1:0]   r_byteIdx;
  logic [31:0]  r_word;
  logic         r_memWrite;
  logic [31:0]  r_writeData;
  logic [31:0]  r_dataAdr;
  logic         r_cpuReset;
  logic         r_busy;
  logic [15:0]  w_lenFull;
  logic         w_lastWord;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]   r_xor;
`endif

  assign w_lenFull  = {r_byteData, r_wordCount[7:0]};
  assign w_lastWord = (r_wordIdx == (r_wordCount - 16'd1));

  // Loader state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ldState <= LD_LEN_LO;
    else       r_ldState <= w_ldNext;
  end

  // Loader next state; a framing error anywhere before DONE is fatal
  always_comb begin
    w_ldNext = r_ldState;
    case (r_ldState)
      LD_LEN_LO: begin
        if (r_byteValid) w_ldNext = LD_LEN_HI;
      end
      LD_LEN_HI: begin
        if (r_byteValid) begin
          if (w_lenFull == 16'd0)             w_ldNext = c_LD_FINISH;
          else if (w_lenFull > c_MAX_WORDS)   w_ldNext = LD_ERROR;
          else                                w_ldNext = LD_DATA;
        end
      end
      LD_DATA: begin
        if (r_byteValid && (r_byteIdx == 2'd3)) w_ldNext = LD_WRITE;
      end
      LD_WRITE: begin
        w_ldNext = w_lastWord ? c_LD_FINISH : LD_DATA;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      LD_CHK: begin
        if (r_byteValid) w_ldNext = (r_byteData == r_xor) ? LD_DONE : LD_ERROR;
      end
`endif
      LD_DONE:  w_ldNext = LD_DONE;
      LD_ERROR: w_ldNext = LD_ERROR;
      default:  w_ldNext = LD_ERROR;
    endcase
    if (r_frameErr && (r_ldState != LD_DONE)) w_ldNext = LD_ERROR;
  end

  // Word assembly, write-port registers, CPU release and busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wordCount <= 16'd0;
      r_wordIdx   <= 16'd0;
      r_byteIdx   <= 2'd0;
      r_word      <= 32'd0;
      r_memWrite  <= 1'b0;
      r_writeData <= 32'd0;
      r_dataAdr   <= BASE_ADDR;
      r_cpuReset  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (r_byteValid && (r_ldState == LD_LEN_LO)) r_wordCount[7:0] <= r_byteData;
      if (r_byteValid && (r_ldState == LD_LEN_HI)) begin
        r_wordCount[15:8] <= r_byteData;
        r_wordIdx         <= 16'd0;
        r_byteIdx         <= 2'd0;
      end
      if (r_byteValid && (r_ldState == LD_DATA)) begin
        r_word[{r_byteIdx, 3'b000} +: 8] <= r_byteData;
        r_byteIdx                        <= r_byteIdx + 2'd1;
      end
      if ((r_ldState == LD_WRITE) && !w_lastWord) r_wordIdx <= r_wordIdx + 16'd1;

      // Strobe, data and address are registered so they line up with WRITE
      r_memWrite <= (w_ldNext == LD_WRITE);
      if (w_ldNext == LD_WRITE) begin
        r_writeData <= {r_byteData, r_word[23:0]};
        r_dataAdr   <= BASE_ADDR + {14'd0, r_wordIdx, 2'b00};
      end

      // Release one cycle after DONE is entered, never during a write
      r_cpuReset <= (r_ldState != LD_DONE);

      if ((w_ldNext == LD_DONE) || (w_ldNext == LD_ERROR)) r_busy <= 1'b0;
      else if (w_startOk)                                  r_busy <= 1'b1;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  // Running XOR of every frame byte before the checksum byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xor <= 8'd0;
    end else if (r_byteValid && ((r_ldState == LD_LEN_LO) ||
                                 (r_ldState == LD_LEN_HI) ||
                                 (r_ldState == LD_DATA))) begin
      r_xor <= r_xor ^ r_byteData;
    end
  end
`endif

  assign ldIf.ext_memwrite  = r_memWrite;
  assign ldIf.ext_writedata = r_writeData;
  assign ldIf.ext_dataadr   = r_dataAdr;
  assign ldIf.cpu_reset     = r_cpuReset;
  assign ldIf.busy          = r_busy;
  assign ldIf.done          = (r_ldState == LD_DONE);
  assign ldIf.err           = (r_ldState == LD_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_mem_loader
// Brief    : Directed self-checking bench for uart_mem_loader at 10 clocks
//            per UART bit, with hand-computed expected words and addresses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_mem_loader;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_mem_loader_if ldIf ();

  uart_mem_loader #(
    .CLK_FREQ  (1000000),
    .BAUD      (100000),
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ldIf (ldIf)
  );

  always #5 clk = ~clk;

  int          checks        = 0;
  int          errors        = 0;
  int          cyc           = 0;
  int          nStrobes      = 0;
  int          lastStrobeCyc = -1;
  int          firstRelCyc   = -1;
  int          violations    = 0;
  logic [31:0] sAdr  [4];
  logic [31:0] sData [4];
  logic [7:0]  frame [$];

  // Cycle counter
  always @(posedge clk) cyc++;

  // Write-port monitor sampled on the falling edge
  always @(negedge clk) begin
    if (ldIf.ext_memwrite) begin
      if (nStrobes < 4) begin
        sAdr[nStrobes]  = ldIf.ext_dataadr;
        sData[nStrobes] = ldIf.ext_writedata;
      end
      nStrobes++;
      lastStrobeCyc = cyc;
      if (!ldIf.cpu_reset) violations++;
    end
    if (!ldIf.cpu_reset && (firstRelCyc < 0)) firstRelCyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkResetVals(input string pfx);
    check({pfx, "_memwrite"},  {31'd0, ldIf.ext_memwrite}, 32'd0);
    check({pfx, "_writedata"}, ldIf.ext_writedata,         32'd0);
    check({pfx, "_dataadr"},   ldIf.ext_dataadr,           32'd0);
    check({pfx, "_cpu_reset"}, {31'd0, ldIf.cpu_reset},    32'd1);
    check({pfx, "_busy"},      {31'd0, ldIf.busy},         32'd0);
    check({pfx, "_done"},      {31'd0, ldIf.done},         32'd0);
    check({pfx, "_err"},       {31'd0, ldIf.err},          32'd0);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    ldIf.rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ldIf.rx = b[i];
      repeat (10) @(negedge clk);
    end
    ldIf.rx = stopBit;
    repeat (10) @(negedge clk);
    ldIf.rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic sendFrame();
    logic [7:0] x;
    x = 8'd0;
    foreach (frame[i]) begin
      x = x ^ frame[i];
      sendByte(frame[i], 1'b1);
    end
`ifdef UART_LOADER_CHECKSUM_EN
    sendByte(x, 1'b1);
`endif
    repeat (20) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nStrobes      = 0;
    lastStrobeCyc = -1;
    firstRelCyc   = -1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    ldIf.rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkResetVals("rst");
    doReset();

    // Short low glitch on an idle line: no byte, no busy, no error
    ldIf.rx = 1'b0;
    repeat (4) @(negedge clk);
    ldIf.rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy",    {31'd0, ldIf.busy}, 32'd0);
    check("glitch_err",     {31'd0, ldIf.err},  32'd0);
    check("glitch_strobes", nStrobes,           32'd0);

    // Two-word image
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hA5, 8'h00};
    sendFrame();
    check("main_strobes",   nStrobes,                32'd2);
    check("main_adr0",      sAdr[0],                 32'h0000_0000);
    check("main_data0",     sData[0],                32'h0010_0513);
    check("main_adr1",      sAdr[1],                 32'h0000_0004);
    check("main_data1",     sData[1],                32'h00A5_05B3);
    check("main_done",      {31'd0, ldIf.done},      32'd1);
    check("main_err",       {31'd0, ldIf.err},       32'd0);
    check("main_busy",      {31'd0, ldIf.busy},      32'd0);
    check("main_cpu_reset", {31'd0, ldIf.cpu_reset}, 32'd0);
    check("main_hold_data", ldIf.ext_writedata,      32'h00A5_05B3);
    check("main_hold_adr",  ldIf.ext_dataadr,        32'h0000_0004);
`ifndef UART_LOADER_CHECKSUM_EN
    check("main_release_lat", firstRelCyc - lastStrobeCyc, 32'd2);
`endif
    // Bytes after DONE are ignored
    sendByte(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    check("done_ignore_strobes", nStrobes,           32'd2);
    check("done_ignore_done",    {31'd0, ldIf.done}, 32'd1);

    // Empty image
    doReset();
    frame = '{8'h00, 8'h00};
    sendFrame();
    check("empty_strobes",   nStrobes,                32'd0);
    check("empty_done",      {31'd0, ldIf.done},      32'd1);
    check("empty_cpu_reset", {31'd0, ldIf.cpu_reset}, 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
    // Empty image with a wrong checksum byte
    doReset();
    sendByte(8'h00, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h01, 1'b1);
    repeat (10) @(negedge clk);
    check("badchk_err",       {31'd0, ldIf.err},       32'd1);
    check("badchk_cpu_reset", {31'd0, ldIf.cpu_reset}, 32'd1);
`endif

    // Oversize length 65
    doReset();
    frame = '{8'h41, 8'h00};
    sendFrame();
    for (int i = 0; i < 4; i++) sendByte(8'h11 + 8'(i), 1'b1);
    repeat (10) @(negedge clk);
    check("big_err",       {31'd0, ldIf.err},       32'd1);
    check("big_cpu_reset", {31'd0, ldIf.cpu_reset}, 32'd1);
    check("big_busy",      {31'd0, ldIf.busy},      32'd0);
    check("big_strobes",   nStrobes,                32'd0);

    // Framing error on the third byte
    doReset();
    sendByte(8'h01, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h11, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_err",       {31'd0, ldIf.err},       32'd1);
    check("ferr_cpu_reset", {31'd0, ldIf.cpu_reset}, 32'd1);
    check("ferr_busy",      {31'd0, ldIf.busy},      32'd0);
    check("ferr_strobes",   nStrobes,                32'd0);

    // Reset mid-frame, then a clean single-word image
    doReset();
    sendByte(8'h01, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'hAA, 1'b1);
    sendByte(8'hBB, 1'b1);
    check("mid_busy", {31'd0, ldIf.busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkResetVals("mid");
    @(negedge clk);
    nStrobes      = 0;
    lastStrobeCyc = -1;
    firstRelCyc   = -1;
    reset = 1'b0;
    @(negedge clk);
    frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sendFrame();
    check("dead_strobes", nStrobes,           32'd1);
    check("dead_adr",     sAdr[0],            32'h0000_0000);
    check("dead_data",    sData[0],           32'hDEAD_BEEF);
    check("dead_done",    {31'd0, ldIf.done}, 32'd1);
`ifndef UART_LOADER_CHECKSUM_EN
    check("dead_release_lat", firstRelCyc - lastStrobeCyc, 32'd2);
`endif

    check("no_write_while_released", violations, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Boot loader that sits directly upstream of the CPU test top.
- Receives a program image over a UART RX line, assembles little-endian 32-bit words and drives the external data-memory write port (ext_memwrite / ext_writedata / ext_dataadr) while holding the CPU in reset.
- Releases cpu_reset once the whole image is written.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 4.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
- MAX_WORDS, 64, largest accepted word count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rx  input  1  UART serial in, idle high, 8N1, LSB first; asynchronous to clk.
- ext_memwrite  output  1  one-cycle write strobe to data memory.
- ext_writedata  output  32  word to write.
- ext_dataadr  output  32  byte address of word.
- cpu_reset  output  1  holds CPU in reset while high.
- busy  output  1  high from first start bit accepted until DONE or ERROR.
- done  output  1  image fully loaded.
- err  output  1  load aborted.

Behaviour:
- Reset values:
  - ext_memwrite=0, ext_writedata=0, ext_dataadr=BASE_ADDR.
  - cpu_reset=1, busy=0, done=0, err=0.
  - Loader FSM=LEN_LO, RX FSM=IDLE, all counters 0.
- rx passes through a 2-flop synchronizer, reset value 1. All RX timing counts from the synchronized signal.
- RX FSM:
  - IDLE: a synchronized 1->0 transition enters START.
  - START: wait CLKS_PER_BIT/2 clocks, then sample. If the sample is 0, go to DATA; if it is 1 (glitch), return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT clocks.
    - Sample 1: emit byte_valid for one cycle with the byte, then IDLE.
    - Sample 0: framing error. No byte is emitted; the loader goes to ERROR.
- Frame format:
  - Bytes 0-1: word count N, 16-bit little-endian.
  - Then 4*N data bytes, little-endian per word (first byte goes to bits [7:0]).
- Loader FSM:
  - LEN_LO: on byte, N[7:0]=byte, go to LEN_HI.
  - LEN_HI: on byte, N[15:8]=byte.
    - N==0: go to DONE (or CHK if CHECKSUM_EN).
    - N>MAX_WORDS: go to ERROR.
    - Otherwise go to DATA with byte index b=0 and word index k=0.
  - DATA: on byte, shift it into word lane b.
    - If b==3, go to WRITE.
    - Otherwise b=b+1.
  - WRITE: lasts exactly one cycle.
    - ext_memwrite=1, ext_writedata=assembled word, ext_dataadr=BASE_ADDR+4*k.
    - If k==N-1, go to DONE (or CHK); otherwise k=k+1, b=0, return to DATA.
  - DONE: done=1, busy=0, cpu_reset=0. Terminal state; further rx bytes are ignored.
  - ERROR: err=1, busy=0, cpu_reset stays 1. Terminal state; exit only via reset.
- Write-port timing:
  - ext_writedata and ext_dataadr are registered.
  - Both are valid in the WRITE cycle and hold their last value afterwards.
  - ext_memwrite is never high outside WRITE.
  - ext_memwrite is never high while cpu_reset=0.
- Release timing: if the last strobe is in cycle T, then in T+1 ext_memwrite=0 and cpu_reset=1; cpu_reset is 0 from T+2 onward.
- Address arithmetic is 32-bit with no wrap check. k is 16 bits wide.
- Framing error in any loader state before DONE forces ERROR.
- Reset asserted mid-frame: everything returns to reset values immediately, including a partial word being dropped and cpu_reset going to 1.
- busy rises in the cycle after the first START sample validates.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE (or after LEN_HI when N==0), the FSM enters CHK and waits for one byte.
  - The expected value is the XOR of all preceding frame bytes, including both length bytes.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
  - With N>0 the data writes have already occurred, but cpu_reset stays 1.
  - Release timing is measured from the CHK byte_valid cycle: cpu_reset is 0 from 2 cycles later.
- Undefined: no CHK state and no XOR register; DONE directly follows the last WRITE.

Test Plan:
- CLK_FREQ=1000000, BAUD=100000 (10 clk/bit), frame 02 00 13 05 10 00 B3 05 A5 00 -> two strobes:
  - adr 0x0 data 0x00100513.
  - adr 0x4 data 0x00A505B3.
  - Then done=1, err=0, cpu_reset=0 exactly 2 cycles after the second strobe.
- Frame 00 00 -> no strobes, done=1, cpu_reset=0. With CHECKSUM_EN, 00 00 00 -> done; 00 00 01 -> err=1, cpu_reset=1.
- Length 41 00 (65 > MAX_WORDS=64) -> err=1, cpu_reset=1, no strobes; later bytes are ignored.
- Stop bit driven 0 on the third byte -> err=1, no strobe, cpu_reset=1.
- 4-clock low glitch on an idle rx -> no byte, busy=0, no error.
- Reset pulsed after 01 00 AA BB -> all outputs at reset values. A following clean frame 01 00 EF BE AD DE writes 0xDEADBEEF at BASE_ADDR.
